// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: data width, default depth, feeder states.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int TXQ_DEPTH   = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } feed_state_t;

endpackage

// File: rtl/uart_txq_fifo.sv
// Synchronous byte FIFO with registered level/empty/full and a registered push-ready.
module uart_txq_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = TXQ_DEPTH,
   parameter int ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   push,
   input  logic                   pop,
   output logic [UART_DATA_W-1:0] head,
   output logic [ADDR_W:0]        level,
   output logic                   empty,
   output logic                   full,
   output logic                   ready
);

   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

   logic [UART_DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]      wr_ptr;
   logic [ADDR_W-1:0]      rd_ptr;
   logic [ADDR_W:0]        level_nxt;
   logic                   do_push;
   logic                   do_pop;

   // ready comes from registered state, so a pop in the same cycle never frees a full slot early
   assign do_push = push & ready;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      if (do_push && !do_pop)
         level_nxt = level + 1'b1;
      else if (!do_push && do_pop)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         ready  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         empty <= (level_nxt == '0);
         full  <= (level_nxt == FULL_LVL);
         ready <= (level_nxt != FULL_LVL);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through WR/DIN/TX_ready.
// Optional UART_TXQ_STATS_EN adds tx_count and drop_seen outputs.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH  = TXQ_DEPTH,
   parameter int ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [UART_DATA_W-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [UART_DATA_W-1:0] uart_din,
   output logic                   uart_wr,
   input  logic                   uart_tx_ready,
   output logic [ADDR_W:0]        level,
   output logic                   empty,
`ifdef UART_TXQ_STATS_EN
   output logic                   full,
   output logic [15:0]            tx_count,
   output logic [0:0]             drop_seen
`else
   output logic                   full
`endif
);

   feed_state_t            state, state_nxt;
   logic [UART_DATA_W-1:0] head;
   logic [UART_DATA_W-1:0] din_nxt;
   logic                   wr_nxt;
   logic                   pop;
   logic                   avail;

   uart_txq_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_data (in_data),
      .push    (in_valid),
      .pop     (pop),
      .head    (head),
      .level   (level),
      .empty   (empty),
      .full    (full),
      .ready   (in_ready)
   );

   // The feeder acts on last cycle's occupancy: a freshly written entry issues two edges after its push.
   always_comb begin
      state_nxt = state;
      din_nxt   = uart_din;
      wr_nxt    = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (avail && !empty && uart_tx_ready) begin
               pop       = 1'b1;
               din_nxt   = head;
               wr_nxt    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:     state_nxt = WAIT_LOW;
         // TX_ready stays high briefly after WR; wait for it to fall before trusting a rise
         WAIT_LOW:  if (!uart_tx_ready) state_nxt = WAIT_HIGH;
         WAIT_HIGH: if (uart_tx_ready)  state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         uart_din <= '0;
         uart_wr  <= 1'b0;
         avail    <= 1'b0;
      end else begin
         state    <= state_nxt;
         uart_din <= din_nxt;
         uart_wr  <= wr_nxt;
         avail    <= ~empty;
      end
   end

`ifdef UART_TXQ_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_count  <= '0;
         drop_seen <= 1'b0;
      end else begin
         if (uart_wr)           tx_count  <= tx_count + 16'd1;
         if (in_valid && full)  drop_seen <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a TX_ready model of UART_comm (low 2 cycles after WR, 50 cycles busy).
module tb_uart_tx_queue;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] uart_din;
   logic       uart_wr;
   logic       uart_tx_ready;
   logic [4:0] level;
   logic       empty;
   logic       full;
`ifdef UART_TXQ_STATS_EN
   logic [15:0] tx_count;
   logic [0:0]  drop_seen;
`endif

   int total = 0;
   int bad = 0;
   logic       force_busy = 1'b0;
   int         t = 0;
   logic [7:0] rx[$];
   logic [7:0] expq[$];
   logic       prev_wr = 1'b0;
   logic       double_wr = 1'b0;
   int         maxlvl = 0;

   always #5 clk = ~clk;

   uart_tx_queue dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .uart_din      (uart_din),
      .uart_wr       (uart_wr),
      .uart_tx_ready (uart_tx_ready),
      .level         (level),
      .empty         (empty),
`ifdef UART_TXQ_STATS_EN
      .full          (full),
      .tx_count      (tx_count),
      .drop_seen     (drop_seen)
`else
      .full          (full)
`endif
   );

   // UART model: sees WR at an edge, stays ready 2 more cycles, then busy for 50
   always @(posedge clk) begin
      if (uart_wr) t <= 1;
      else if (t != 0) t <= (t == 52) ? 0 : t + 1;
   end
   assign uart_tx_ready = (t < 3) && !force_busy;

   always @(negedge clk) begin
      if (rst_n && uart_wr) rx.push_back(uart_din);
      if (uart_wr && prev_wr) double_wr = 1'b1;
      prev_wr = uart_wr;
      if (int'(level) > maxlvl) maxlvl = int'(level);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check("push_timeout", 32'd1, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_rx(input int cnt, input int budget);
      int n = 0;
      while (rx.size() < cnt && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check("rx_timeout", 32'(rx.size()), 32'(cnt));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((t != 0 || !empty) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("idle_timeout", 32'(t), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n0;
      // 1: reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr", 32'(uart_wr), 32'd0);
      check("rst_din", 32'(uart_din), 32'h00);
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rel", 32'(in_ready), 32'd1);

      // 2: single byte latency
      rx.delete();
      in_data  = 8'hA5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("a5_e1_wr", 32'(uart_wr), 32'd0);
      check("a5_e1_level", 32'(level), 32'd1);
      check("a5_e1_empty", 32'(empty), 32'd0);
      @(negedge clk);
      check("a5_e2_wr", 32'(uart_wr), 32'd0);
      @(negedge clk);
      check("a5_e3_wr", 32'(uart_wr), 32'd1);
      check("a5_e3_din", 32'(uart_din), 32'hA5);
      check("a5_e3_level", 32'(level), 32'd0);
      @(negedge clk);
      check("a5_e4_wr", 32'(uart_wr), 32'd0);
      repeat (60) @(negedge clk);
      check("a5_wr_count", 32'(rx.size()), 32'd1);
      if (rx.size() > 0) check("a5_byte", 32'(rx[0]), 32'hA5);

      // 3: fill while busy, reject overflow, then drain in order
      wait_idle();
      rx.delete();
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i));
      check("fill_full", 32'(full), 32'd1);
      check("fill_level", 32'(level), 32'd16);
      check("fill_in_ready", 32'(in_ready), 32'd0);
      in_data  = 8'hFF;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check("ovf_level", 32'(level), 32'd16);
      force_busy = 1'b0;
      wait_rx(16, 1500);
      repeat (60) @(negedge clk);
      check("drain_count", 32'(rx.size()), 32'd16);
      for (int i = 0; i < 16 && i < rx.size(); i++) check("drain_order", 32'(rx[i]), 32'(i));

      // 4: random gaps while draining, pointers wrap
      wait_idle();
      rx.delete();
      expq.delete();
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         expq.push_back(b);
         push(b);
      end
      wait_rx(40, 3000);
      check("rand_count", 32'(rx.size()), 32'd40);
      for (int i = 0; i < 40 && i < rx.size(); i++) check("rand_order", 32'(rx[i]), 32'(expq[i]));
      check("max_level", 32'(maxlvl <= 16), 32'd1);

      // 5: reset with bytes queued and the UART busy
      wait_idle();
      force_busy = 1'b1;
      for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
      check("q3_level", 32'(level), 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_empty", 32'(empty), 32'd1);
      n0 = rx.size();
      repeat (10) @(negedge clk);
      force_busy = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_no_wr", 32'(rx.size()), 32'(n0));
      push(8'h3C);
      wait_rx(n0 + 1, 100);
      if (rx.size() > n0) check("post_rst_byte", 32'(rx[n0]), 32'h3C);

`ifdef UART_TXQ_STATS_EN
      // 6: statistics
      wait_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("st_rst_cnt", 32'(tx_count), 32'd0);
      check("st_rst_drop", 32'(drop_seen), 32'd0);
      rx.delete();
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
      wait_rx(5, 600);
      wait_idle();
      check("st_cnt5", 32'(tx_count), 32'd5);
      check("st_drop0", 32'(drop_seen), 32'd0);
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) push(8'(i));
      in_data  = 8'h77;
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      check("st_drop1", 32'(drop_seen), 32'd1);
      check("st_cnt_hold", 32'(tx_count), 32'd5);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("st_clr_cnt", 32'(tx_count), 32'd0);
      check("st_clr_drop", 32'(drop_seen), 32'd0);
      force_busy = 1'b0;
`endif

      check("wr_single_cycle", 32'(double_wr), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
